huffman_bitpacker: RTL
======================

# huffman_bitpacker

Serialises variable-length Huffman symbols into a JPEG entropy-coded byte stream. It sits directly downstream of the DC (and later AC) Huffman encoders and consumes their registered 33-bit symbol tuples. It appends code bits then amplitude bits MSB-first into a bit buffer and emits bytes with 0xFF→0xFF 0x00 stuffing. On request it pads the final partial byte with 1s.

## Interface
- No parameters. Widths are fixed by the upstream tuple format.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 33: symbol tuple `{code[32:24], code_len[23:16], amp[15:8], amp_len[7:0]}`. Valid bits of `code` and `amp` are right-aligned.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the symbol is accepted when `in_valid && in_ready`.
- `flush` in 1: single-cycle request to pad and drain.
- `out_byte` out 8: stream byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte when `out_valid && out_ready`.
- `flush_done` out 1: one-cycle pulse when the flush has completed.

## Operation
- Length clamps: `code_len` > 9 is treated as 9; `amp_len` > 8 is treated as 8. Zero lengths are legal and contribute no bits.
- Each symbol contributes at most 17 bits.
- State: 32-bit buffer `buf`, left-aligned (MSB = oldest bit); 6-bit `count`; output register; `stuff_pending` flag.
- Accepting a symbol appends `code_len` code bits, then `amp_len` amplitude bits, starting at buffer position `count`. Then `count += code_len + amp_len`.
- `in_ready = (state==RUN) && count <= 15 && !rst`.
- Output register load slot: a slot occurs when `!out_valid || out_ready`.
  - If `stuff_pending`, load 0x00 and clear the flag.
  - Else, if `count >= 8`, load `buf[31:24]`, shift `buf` left by 8, and `count -= 8`. If the loaded byte is 0xFF, set `stuff_pending`.
  - Else, clear `out_valid`.
- An accept and a drain in the same cycle combine: `count' = count - 8 + n`. Appended bits land at position `count - 8`.
- FSM states: RUN, PAD, DRAIN.
  - RUN → PAD on `flush`. `in_ready` is low from the next cycle. A symbol accepted in the same cycle as `flush` is included.
  - PAD: if `count mod 8 != 0`, fill the bits up to the next byte boundary with 1s and round `count` up. Go to DRAIN after 1 cycle.
  - DRAIN: drain using normal load slots, including stuffing. When `count==0`, `!stuff_pending`, and the output register is empty or being consumed, pulse `flush_done` and return to RUN.
- `flush` while not in RUN is ignored.
- Reset values: `out_byte=0`, `out_valid=0`, `flush_done=0`, `in_ready=0` during reset, `buf=0`, `count=0`, `stuff_pending=0`, state RUN.
- Reset mid-operation discards all buffered bits with no partial output.

## Timing
- Latency: a symbol that completes a byte, accepted in cycle t, gives `out_valid` in cycle t+2.
- Throughput: 1 byte/cycle while `out_ready` is high. Stuff bytes take one slot each.
- `out_byte` and `out_valid` are registered. They stay stable while `out_valid && !out_ready`.
- `in_ready` is combinational from registered `state` and `count` only. It does not depend on `in_valid`.
- Flush with `count==0` and the output register empty: PAD(1) → DRAIN(1). `flush_done` pulses in cycle t+2 after `flush` at cycle t.

## Structure
- Shared package `jpeg_enc_pkg` holds:
  - the tuple field positions;
  - `SYM_W=33`, `CODE_MAX=9`, `AMP_MAX=8`, `BUF_W=32`;
  - the stuff-byte constant 0xFF;
  - the FSM state enum.
- No sub-module is needed. The bit-append shift can be a function in the package.

## Test plan
- Pad: symbol code=3'b110 len 3, amp=3'b101 len 3, then flush. Expect one byte 0xD7, then `flush_done`.
- Merge: four symbols code=2'b00 len 2, amp_len 0. Expect exactly one byte 0x00, at cycle accept-of-4th + 2.
- Stuffing: code=9'h0FF len 8, amp_len 0. Expect bytes 0xFF, then 0x00, on consecutive cycles.
- Backpressure: stream 0xFF-producing symbols with `out_ready` low for 5 cycles.
  - `out_byte` stays constant.
  - `in_ready` falls once `count` > 15.
  - No bytes are lost; the sequence is 0xFF,0x00,0xFF,0x00.
- Clamp/boundary: code_len=12 and amp_len=10 with all-ones data. 17 bits are appended. Flush output is 0xFF,0x00,0xFF,0x00,0xFF,0x00.
- Reset mid-operation: assert `rst` with `count`=12 and `out_valid` high.
  - Outputs go to 0 immediately.
  - After release, a flush gives `flush_done` with no bytes.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG entropy-coding path: symbol tuple layout,
// bit-buffer geometry and the bit packer FSM states.
package jpeg_enc_pkg;

  localparam int SYM_W    = 33;
  localparam int CODE_MAX = 9;
  localparam int AMP_MAX  = 8;
  localparam int BUF_W    = 32;

  localparam int CODE_HI = 32;
  localparam int CODE_LO = 24;
  localparam int CLEN_HI = 23;
  localparam int CLEN_LO = 16;
  localparam int AMP_HI  = 15;
  localparam int AMP_LO  = 8;
  localparam int ALEN_HI = 7;
  localparam int ALEN_LO = 0;

  localparam logic [7:0] STUFF_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAD,
    ST_DRAIN
  } pack_state_t;

  // Right-aligned field of 'len' bits placed so its MSB sits at buffer position
  // 'pos' (0 = buffer MSB). The caller guarantees pos + len <= BUF_W.
  function automatic logic [BUF_W-1:0] place_bits(input logic [BUF_W-1:0] bits,
                                                  input logic [5:0] pos,
                                                  input logic [5:0] len);
    return (bits << (6'd32 - len)) >> pos;
  endfunction

endpackage

// File: rtl/huffman_bitpacker.sv
// Packs clamped Huffman code/amplitude fields MSB-first into a 32-bit buffer and
// emits a byte stream with 0xFF 0x00 stuffing; flush pads the tail with 1s.
module huffman_bitpacker
  import jpeg_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flush_done
);

  pack_state_t      state_reg;
  logic [BUF_W-1:0] buf_reg;
  logic [5:0]       count_reg;
  logic [7:0]       out_byte_reg;
  logic             out_valid_reg;
  logic             stuff_pending_reg;

  logic [3:0]       code_len_c;
  logic [3:0]       amp_len_c;
  logic [16:0]      code_v;
  logic [16:0]      amp_v;
  logic [BUF_W-1:0] sym_bits;
  logic [5:0]       sym_len;
  logic             slot;
  logic             drain;
  logic             accept;
  logic [BUF_W-1:0] base_buf;
  logic [5:0]       base_count;
  logic [2:0]       pad_len;
  logic [BUF_W-1:0] pad_ones;
  logic             done;

  assign in_ready = (state_reg == ST_RUN) && (count_reg <= 6'd15) && !rst;

  always_comb begin
    code_len_c = (in_data[CLEN_HI:CLEN_LO] > 8'(CODE_MAX)) ? 4'(CODE_MAX)
                                                            : in_data[CLEN_LO+3:CLEN_LO];
    amp_len_c  = (in_data[ALEN_HI:ALEN_LO] > 8'(AMP_MAX)) ? 4'(AMP_MAX)
                                                           : in_data[ALEN_LO+3:ALEN_LO];
    // Mask away anything above the clamped lengths so stray upper bits never leak in.
    code_v   = {8'b0, in_data[CODE_HI:CODE_LO]} & ((17'd1 << code_len_c) - 17'd1);
    amp_v    = {9'b0, in_data[AMP_HI:AMP_LO]} & ((17'd1 << amp_len_c) - 17'd1);
    sym_bits = {15'b0, (code_v << amp_len_c) | amp_v};
    sym_len  = {2'b0, code_len_c} + {2'b0, amp_len_c};
  end

  assign slot   = !out_valid_reg || out_ready;
  assign drain  = slot && !stuff_pending_reg && (count_reg >= 6'd8);
  assign accept = in_valid && in_ready;

  // Buffer view after this cycle's byte removal; appends and padding land here.
  assign base_buf   = drain ? (buf_reg << 8) : buf_reg;
  assign base_count = drain ? (count_reg - 6'd8) : count_reg;
  assign pad_len    = 3'd0 - base_count[2:0];
  assign pad_ones   = (32'd1 << pad_len) - 32'd1;

  assign done = (state_reg == ST_DRAIN) && (count_reg == 6'd0) && !stuff_pending_reg && slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_RUN;
      buf_reg           <= '0;
      count_reg         <= '0;
      out_byte_reg      <= '0;
      out_valid_reg     <= 1'b0;
      stuff_pending_reg <= 1'b0;
    end else begin
      buf_reg   <= base_buf;
      count_reg <= base_count;
      if (accept) begin
        buf_reg   <= base_buf | place_bits(sym_bits, base_count, sym_len);
        count_reg <= base_count + sym_len;
      end

      if (slot) begin
        if (stuff_pending_reg) begin
          out_byte_reg      <= 8'h00;
          out_valid_reg     <= 1'b1;
          stuff_pending_reg <= 1'b0;
        end else if (drain) begin
          out_byte_reg      <= buf_reg[31:24];
          out_valid_reg     <= 1'b1;
          stuff_pending_reg <= (buf_reg[31:24] == STUFF_BYTE);
        end else begin
          out_valid_reg <= 1'b0;
        end
      end

      case (state_reg)
        ST_RUN: begin
          if (flush) state_reg <= ST_PAD;
        end
        ST_PAD: begin
          buf_reg   <= base_buf | place_bits(pad_ones, base_count, {3'b0, pad_len});
          count_reg <= base_count + {3'b0, pad_len};
          state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (done) state_reg <= ST_RUN;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign out_byte   = out_byte_reg;
  assign out_valid  = out_valid_reg;
  assign flush_done = done;

endmodule
